// File: rtl/me_pixel_feeder.sv
// me_pixel_feeder
// ----------------
// Front end for the motion-estimation PE chain. For one block search it
// walks every vertical offset dy (0..2*SR) and block row (0..BLK-1). For each
// pair it first loads BLK current-block pixels into the chain (crt_keep=0),
// in reverse column order so PE[k] ends holding column k. It then holds those
// pixels (crt_keep=1) while one WIN-wide search-window row streams past.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a block search (ignored while busy)
//   crt_base/crt_stride   current block origin / row pitch, latched on start
//   pre_base/pre_stride   search window origin / row pitch, latched on start
//   crt_rd_en/addr/data   current frame-buffer read port (data 1 cycle later)
//   pre_rd_en/addr/data   previous frame-buffer read port (data 1 cycle later)
//   crt_pixel, crt_keep   to PE[0] current-pixel input and chain hold control
//   pre_pixel, pre_valid  to PE[0] search-window input and its qualifier
//   dy_idx, row_idx       offset / block row of the pixel now on the outputs
//   busy, done            search in progress / 1-cycle completion pulse
//   abort, aborted        present only with ME_FEEDER_ABORT_EN defined
//
// Optional feature macro: ME_FEEDER_ABORT_EN. When it is defined, abort while
// busy cancels the search. The outputs are 2 cycles behind the read address.
module me_pixel_feeder #(
  parameter  int PW  = 8,
  parameter  int BLK = 16,
  parameter  int SR  = 8,
  parameter  int CAW = 10,
  parameter  int PAW = 14,
  localparam int WIN = BLK + 2*SR,
  localparam int DYW = (SR > 0) ? $clog2(2*SR+1) : 1,
  localparam int RW  = (BLK > 1) ? $clog2(BLK) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef ME_FEEDER_ABORT_EN
  input  logic           abort,
  output logic           aborted,
`endif
  input  logic [CAW-1:0] crt_base,
  input  logic [CAW-1:0] crt_stride,
  input  logic [PAW-1:0] pre_base,
  input  logic [PAW-1:0] pre_stride,
  output logic           crt_rd_en,
  output logic [CAW-1:0] crt_rd_addr,
  input  logic [PW-1:0]  crt_rd_data,
  output logic           pre_rd_en,
  output logic [PAW-1:0] pre_rd_addr,
  input  logic [PW-1:0]  pre_rd_data,
  output logic [PW-1:0]  crt_pixel,
  output logic           crt_keep,
  output logic [PW-1:0]  pre_pixel,
  output logic           pre_valid,
  output logic [DYW-1:0] dy_idx,
  output logic [RW-1:0]  row_idx,
  output logic           busy,
  output logic           done
);

  // The column counter also times LOAD and the 2-cycle DRAIN; WIN is the longest phase.
  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  localparam logic [CW-1:0]  LOAD_LAST   = CW'(BLK - 1);
  localparam logic [CW-1:0]  STREAM_LAST = CW'(WIN - 1);
  localparam logic [CW-1:0]  DRAIN_LAST  = CW'(1);
  localparam logic [RW-1:0]  ROW_LAST    = RW'(BLK - 1);
  localparam logic [DYW-1:0] DY_LAST     = DYW'(2*SR);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DYW-1:0]  dy_q, dy_d;
  logic [CAW-1:0]  crt_base_q, crt_base_d, crt_stride_q, crt_stride_d;
  logic [PAW-1:0]  pre_base_q, pre_base_d, pre_stride_q, pre_stride_d;
  // The row offsets are kept as running sums, so no multiplier is needed:
  //   crt_acc    = row*crt_stride
  //   pre_acc    = (dy+row)*pre_stride
  //   pre_dy_acc = dy*pre_stride
  logic [CAW-1:0]  crt_acc_q, crt_acc_d;
  logic [PAW-1:0]  pre_acc_q, pre_acc_d;
  logic [PAW-1:0]  pre_dy_acc_q, pre_dy_acc_d;

  logic            crt_en, pre_en, last_issue;
  logic            abort_hit;

  // Stage 1 tracks the read in flight. The frame buffers return data in this cycle.
  logic            s1_load_q, s1_load_d;
  logic            s1_stream_q, s1_stream_d;
  logic            s1_last_q, s1_last_d;
  logic [DYW-1:0]  s1_dy_q, s1_dy_d;
  logic [RW-1:0]   s1_row_q, s1_row_d;

  // Stage 2 holds the output registers.
  logic [PW-1:0]   crt_pixel_q, crt_pixel_d;
  logic            crt_keep_q, crt_keep_d;
  logic [PW-1:0]   pre_pixel_q, pre_pixel_d;
  logic            pre_valid_q, pre_valid_d;
  logic [DYW-1:0]  dy_idx_q, dy_idx_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic            done_q, done_d;

`ifdef ME_FEEDER_ABORT_EN
  logic            aborted_q;
  assign abort_hit = abort && (state_q != IDLE);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state logic and read issue.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    dy_d         = dy_q;
    crt_base_d   = crt_base_q;
    crt_stride_d = crt_stride_q;
    pre_base_d   = pre_base_q;
    pre_stride_d = pre_stride_q;
    crt_acc_d    = crt_acc_q;
    pre_acc_d    = pre_acc_q;
    pre_dy_acc_d = pre_dy_acc_q;
    crt_en       = 1'b0;
    pre_en       = 1'b0;
    last_issue   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          crt_base_d   = crt_base;
          crt_stride_d = crt_stride;
          pre_base_d   = pre_base;
          pre_stride_d = pre_stride;
          col_d        = '0;
          row_d        = '0;
          dy_d         = '0;
          crt_acc_d    = '0;
          pre_acc_d    = '0;
          pre_dy_acc_d = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        crt_en = 1'b1;
        if (col_q == LOAD_LAST) begin
          col_d   = '0;
          state_d = STREAM;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      STREAM: begin
        pre_en = 1'b1;
        if (col_q == STREAM_LAST) begin
          col_d = '0;
          if (row_q != ROW_LAST) begin
            row_d     = row_q + 1'b1;
            crt_acc_d = crt_acc_q + crt_stride_q;
            pre_acc_d = pre_acc_q + pre_stride_q;
            state_d   = LOAD;
          end else if (dy_q != DY_LAST) begin
            // The next offset restarts at block row 0, i.e. window row dy+1.
            row_d        = '0;
            dy_d         = dy_q + 1'b1;
            crt_acc_d    = '0;
            pre_dy_acc_d = pre_dy_acc_q + pre_stride_q;
            pre_acc_d    = pre_dy_acc_q + pre_stride_q;
            state_d      = LOAD;
          end else begin
            last_issue = 1'b1;
            state_d    = DRAIN;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        // Give the last two reads time to clear the pipeline before dropping busy.
        if (col_q == DRAIN_LAST) begin
          col_d   = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_hit) begin
      state_d    = IDLE;
      col_d      = '0;
      crt_en     = 1'b0;
      pre_en     = 1'b0;
      last_issue = 1'b0;
    end
  end

  // Load columns run in reverse (BLK-1 down to 0). Each new pixel pushes the
  // earlier ones deeper into the chain.
  assign crt_rd_en   = crt_en;
  assign crt_rd_addr = crt_en ? (crt_base_q + crt_acc_q + CAW'(BLK - 1) - CAW'(col_q)) : '0;
  assign pre_rd_en   = pre_en;
  assign pre_rd_addr = pre_en ? (pre_base_q + pre_acc_q + PAW'(col_q)) : '0;
  assign busy        = (state_q != IDLE);

  // Pipeline stages.
  always_comb begin
    s1_load_d   = crt_en;
    s1_stream_d = pre_en;
    s1_last_d   = last_issue;
    s1_dy_d     = (crt_en || pre_en) ? dy_q : '0;
    s1_row_d    = (crt_en || pre_en) ? row_q : '0;

    // During STREAM and bubbles, crt_pixel keeps the last loaded value.
    crt_pixel_d = s1_load_q ? crt_rd_data : crt_pixel_q;
    crt_keep_d  = ~s1_load_q;
    pre_pixel_d = s1_stream_q ? pre_rd_data : '0;
    pre_valid_d = s1_stream_q;
    dy_idx_d    = s1_dy_q;
    row_idx_d   = s1_row_q;
    done_d      = s1_last_q;

    if (abort_hit) begin
      crt_pixel_d = crt_pixel_q;
      crt_keep_d  = 1'b1;
      pre_pixel_d = '0;
      pre_valid_d = 1'b0;
      dy_idx_d    = '0;
      row_idx_d   = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      dy_q         <= '0;
      crt_base_q   <= '0;
      crt_stride_q <= '0;
      pre_base_q   <= '0;
      pre_stride_q <= '0;
      crt_acc_q    <= '0;
      pre_acc_q    <= '0;
      pre_dy_acc_q <= '0;
      s1_load_q    <= 1'b0;
      s1_stream_q  <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_dy_q      <= '0;
      s1_row_q     <= '0;
      crt_pixel_q  <= '0;
      crt_keep_q   <= 1'b1;
      pre_pixel_q  <= '0;
      pre_valid_q  <= 1'b0;
      dy_idx_q     <= '0;
      row_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      dy_q         <= dy_d;
      crt_base_q   <= crt_base_d;
      crt_stride_q <= crt_stride_d;
      pre_base_q   <= pre_base_d;
      pre_stride_q <= pre_stride_d;
      crt_acc_q    <= crt_acc_d;
      pre_acc_q    <= pre_acc_d;
      pre_dy_acc_q <= pre_dy_acc_d;
      s1_load_q    <= s1_load_d;
      s1_stream_q  <= s1_stream_d;
      s1_last_q    <= s1_last_d;
      s1_dy_q      <= s1_dy_d;
      s1_row_q     <= s1_row_d;
      crt_pixel_q  <= crt_pixel_d;
      crt_keep_q   <= crt_keep_d;
      pre_pixel_q  <= pre_pixel_d;
      pre_valid_q  <= pre_valid_d;
      dy_idx_q     <= dy_idx_d;
      row_idx_q    <= row_idx_d;
      done_q       <= done_d;
    end
  end

`ifdef ME_FEEDER_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`endif

  assign crt_pixel = crt_pixel_q;
  assign crt_keep  = crt_keep_q;
  assign pre_pixel = pre_pixel_q;
  assign pre_valid = pre_valid_q;
  assign dy_idx    = dy_idx_q;
  assign row_idx   = row_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Testbench for me_pixel_feeder with BLK=4, SR=1 (WIN=6) and 120 issue cycles
// per search. Both frame buffers return pixel = low byte of the address.
module tb_me_pixel_feeder;
  localparam int PW   = 8;
  localparam int BLK  = 4;
  localparam int SR   = 1;
  localparam int CAW  = 10;
  localparam int PAW  = 14;
  localparam int WIN  = BLK + 2*SR;
  localparam int RL   = BLK + WIN;              // issue cycles per block row
  localparam int NISS = (2*SR + 1) * BLK * RL;  // 120

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [CAW-1:0] crt_base = '0, crt_stride = '0;
  logic [PAW-1:0] pre_base = '0, pre_stride = '0;
  logic           crt_rd_en, pre_rd_en;
  logic [CAW-1:0] crt_rd_addr;
  logic [PAW-1:0] pre_rd_addr;
  logic [PW-1:0]  crt_rd_data = '0, pre_rd_data = '0;
  logic [PW-1:0]  crt_pixel, pre_pixel;
  logic           crt_keep, pre_valid, busy, done;
  logic [1:0]     dy_idx, row_idx;
`ifdef ME_FEEDER_ABORT_EN
  logic           abort = 1'b0;
  logic           aborted;
`endif

  int checks = 0;
  int failures = 0;

  me_pixel_feeder #(.PW(PW), .BLK(BLK), .SR(SR), .CAW(CAW), .PAW(PAW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ME_FEEDER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .crt_base(crt_base), .crt_stride(crt_stride),
    .pre_base(pre_base), .pre_stride(pre_stride),
    .crt_rd_en(crt_rd_en), .crt_rd_addr(crt_rd_addr), .crt_rd_data(crt_rd_data),
    .pre_rd_en(pre_rd_en), .pre_rd_addr(pre_rd_addr), .pre_rd_data(pre_rd_data),
    .crt_pixel(crt_pixel), .crt_keep(crt_keep),
    .pre_pixel(pre_pixel), .pre_valid(pre_valid),
    .dy_idx(dy_idx), .row_idx(row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame buffer models: pixel value = address low byte, one cycle latency.
  always @(posedge clk) begin
    if (crt_rd_en) crt_rd_data <= crt_rd_addr[PW-1:0];
    if (pre_rd_en) pre_rd_data <= pre_rd_addr[PW-1:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present start in the current cycle ("cycle 0").
  task automatic go(input int cb, input int cs, input int pb, input int ps);
    crt_base   = CAW'(cb);
    crt_stride = CAW'(cs);
    pre_base   = PAW'(pb);
    pre_stride = PAW'(ps);
    start      = 1'b1;
  endtask

  function automatic logic [CAW-1:0] m_crt(input int cb, input int cs, input int row, input int pos);
    return CAW'(cb + row*cs + (BLK - 1 - pos));
  endfunction

  function automatic logic [PAW-1:0] m_pre(input int pb, input int ps, input int dy, input int row, input int col);
    return PAW'(pb + (dy + row)*ps + col);
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, crt_rd_en, pre_rd_en, pre_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, crt_rd_en, pre_rd_en, pre_valid});
    end
    checks++;
    if (crt_keep !== 1'b1) begin
      failures++;
      $display("FAIL reset_keep: got %b expected 1", crt_keep);
    end
    checks++;
    if ({crt_pixel, pre_pixel, dy_idx, row_idx} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {crt_pixel, pre_pixel, dy_idx, row_idx});
    end
    checks++;
    if ({crt_rd_addr, pre_rd_addr} !== 24'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h expected 0", {crt_rd_addr, pre_rd_addr});
    end
    $display("test_reset done");
  endtask

  task automatic test_timing();
    int issues = 0, dcnt = 0, dcyc = -1, bfirst = -1, blast = -1, bcnt = 0;
    logic fen = 1'b0, done_pv = 1'b0;
    logic [CAW-1:0] faddr = '0;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        fen = crt_rd_en;
        faddr = crt_rd_addr;
      end
      if (crt_rd_en === 1'b1 || pre_rd_en === 1'b1) issues++;
      if (done === 1'b1) begin
        dcnt++;
        dcyc = c;
        done_pv = pre_valid;
      end
      if (busy === 1'b1) begin
        bcnt++;
        if (bfirst < 0) bfirst = c;
        blast = c;
      end
    end
    checks++;
    if (issues != NISS) begin failures++; $display("FAIL timing_issues: got %0d expected %0d", issues, NISS); end
    checks++;
    if (fen !== 1'b1 || faddr !== 10'd3) begin failures++; $display("FAIL timing_first_addr: got en=%b addr=%0d expected en=1 addr=3", fen, faddr); end
    checks++;
    if (dcnt != 1 || dcyc != 122) begin failures++; $display("FAIL timing_done: got count=%0d cycle=%0d expected count=1 cycle=122", dcnt, dcyc); end
    checks++;
    if (done_pv !== 1'b1) begin failures++; $display("FAIL timing_done_pv: got pre_valid=%b expected 1", done_pv); end
    checks++;
    if (bfirst != 1 || blast != 122 || bcnt != 122) begin
      failures++;
      $display("FAIL timing_busy: got first=%0d last=%0d count=%0d expected 1 122 122", bfirst, blast, bcnt);
    end
    $display("test_timing done: issues=%0d done_cycle=%0d", issues, dcyc);
  endtask

  // Per-cycle check of issued addresses and of the output stream.
  task automatic test_data();
    logic [PW-1:0]  hold = '0;
    logic [PW-1:0]  first4 [4];
    logic [PW-1:0]  s24 [6];
    int nload = 0, n24 = 0;
    logic           ece, epe;
    logic [CAW-1:0] eca, ca;
    logic [PAW-1:0] epa, pa;
    logic [23:0]    exp_o, got_o;
    logic [PW-1:0]  ecp, epp;
    logic           ekeep, epv, edone, ebusy;
    logic [1:0]     edy, erow;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 126; c++) begin
      int i, j, pos, blk, dy, row;
      tick();
      if (c == 1) start = 1'b0;
      i = c - 1;
      ece = 1'b0; epe = 1'b0; eca = '0; epa = '0;
      if (i < NISS) begin
        pos = i % RL; blk = i / RL; dy = blk / BLK; row = blk % BLK;
        if (pos < BLK) begin ece = 1'b1; eca = m_crt(0, 4, row, pos); end
        else begin epe = 1'b1; epa = m_pre(0, 8, dy, row, pos - BLK); end
      end
      checks++;
      if ({crt_rd_en, pre_rd_en, crt_rd_addr, pre_rd_addr} !== {ece, epe, eca, epa}) begin
        failures++;
        $display("FAIL issue c=%0d: got en=%b%b ca=%0d pa=%0d expected en=%b%b ca=%0d pa=%0d",
                 c, crt_rd_en, pre_rd_en, crt_rd_addr, pre_rd_addr, ece, epe, eca, epa);
      end
      j = c - 3;
      ekeep = 1'b1; epv = 1'b0; epp = '0; edy = '0; erow = '0; edone = 1'b0;
      if (j >= 0 && j < NISS) begin
        pos = j % RL; blk = j / RL; dy = blk / BLK; row = blk % BLK;
        edy = 2'(dy); erow = 2'(row);
        if (pos < BLK) begin
          ca = m_crt(0, 4, row, pos);
          ekeep = 1'b0;
          hold = ca[PW-1:0];
        end else begin
          pa = m_pre(0, 8, dy, row, pos - BLK);
          epv = 1'b1;
          epp = pa[PW-1:0];
        end
        edone = (j == NISS - 1);
      end
      ecp = hold;
      ebusy = (c <= 122);
      exp_o = {ebusy, edone, ekeep, ecp, epv, epp, edy, erow};
      got_o = {busy, done, crt_keep, crt_pixel, pre_valid, pre_pixel, dy_idx, row_idx};
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL output c=%0d: got busy/done/keep/cp/pv/pp/dy/row=%h expected %h", c, got_o, exp_o);
      end
      if (crt_keep === 1'b0 && nload < 4) begin first4[nload] = crt_pixel; nload++; end
      if (pre_valid === 1'b1 && dy_idx === 2'd1 && row_idx === 2'd2 && n24 < 6) begin s24[n24] = pre_pixel; n24++; end
    end
    checks++;
    if (nload != 4) begin
      failures++;
      $display("FAIL load_order_count: got %0d expected 4", nload);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (first4[k] !== PW'(3 - k)) begin failures++; $display("FAIL load_order[%0d]: got %0d expected %0d", k, first4[k], 3 - k); end
      end
    end
    checks++;
    if (n24 != 6) begin
      failures++;
      $display("FAIL stream_dy1_row2_count: got %0d expected 6", n24);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (s24[k] !== PW'(24 + k)) begin failures++; $display("FAIL stream_dy1_row2[%0d]: got %0d expected %0d", k, s24[k], 24 + k); end
      end
    end
    $display("test_data done");
  endtask

  task automatic test_wrap();
    int issues = 0, dcyc = -1;
    logic [CAW-1:0] eca;
    do_reset();
    go(1020, 4, 0, 8);
    for (int c = 1; c <= 126; c++) begin
      int i, pos, blk, row;
      tick();
      if (c == 1) start = 1'b0;
      if (crt_rd_en === 1'b1 || pre_rd_en === 1'b1) issues++;
      if (done === 1'b1) dcyc = c;
      i = c - 1;
      if (i < NISS) begin
        pos = i % RL; blk = i / RL; row = blk % BLK;
        if (pos < BLK) begin
          eca = m_crt(1020, 4, row, pos);
          checks++;
          if (crt_rd_en !== 1'b1 || $isunknown(crt_rd_addr) || crt_rd_addr !== eca) begin
            failures++;
            $display("FAIL wrap_addr c=%0d: got en=%b addr=%0d expected en=1 addr=%0d", c, crt_rd_en, crt_rd_addr, eca);
          end
        end
      end
      if (c == 3) begin
        checks++;
        if (crt_pixel !== 8'hFF) begin failures++; $display("FAIL wrap_pix_1023: got %0d expected 255", crt_pixel); end
      end
      if (c == 13) begin
        checks++;
        if (crt_pixel !== 8'd3) begin failures++; $display("FAIL wrap_pix_row1: got %0d expected 3", crt_pixel); end
      end
    end
    checks++;
    if (issues != NISS || dcyc != 122) begin
      failures++;
      $display("FAIL wrap_counts: got issues=%0d done=%0d expected %0d 122", issues, dcyc, NISS);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    int dpre = 0, dcnt = 0, drel = -1;
    logic [7:0] got;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (done === 1'b1) dpre++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {busy, done, crt_rd_en, pre_rd_en, pre_valid, crt_keep, 2'b00};
    checks++;
    if (got !== 8'b0000_0100 || crt_pixel !== 8'h0 || pre_pixel !== 8'h0 || {dy_idx, row_idx} !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ctrl=%b cp=%0d pp=%0d dyrow=%h expected ctrl=00000100 cp=0 pp=0 dyrow=0",
               got, crt_pixel, pre_pixel, {dy_idx, row_idx});
    end
    tick();
    if (done === 1'b1) dpre++;
    go(0, 4, 0, 8);
    for (int r = 1; r <= 130; r++) begin
      tick();
      if (r == 1) start = 1'b0;
      if (done === 1'b1) begin dcnt++; drel = r; end
      if (r == 3) begin
        checks++;
        if (crt_pixel !== 8'd3 || crt_keep !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_first_pix: got %0d keep=%b expected 3 keep=0", crt_pixel, crt_keep);
        end
      end
    end
    checks++;
    if (dpre != 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d expected 0", dpre); end
    checks++;
    if (dcnt != 1 || drel != 122) begin
      failures++;
      $display("FAIL reset_mid_restart: got count=%0d cycle=%0d expected 1 122", dcnt, drel);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_start_busy();
    int dcnt = 0, dcyc = -1;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 30) begin
        start = 1'b1;
        crt_base = 10'd100;
        pre_base = 14'd200;
      end
      if (c == 31) start = 1'b0;
      if (done === 1'b1) begin dcnt++; dcyc = c; end
      if (c == 111) begin
        checks++;
        if (crt_rd_addr !== 10'd15) begin failures++; $display("FAIL busy_start_crt: got %0d expected 15", crt_rd_addr); end
      end
      if (c == 120) begin
        checks++;
        if (pre_rd_addr !== 14'd45) begin failures++; $display("FAIL busy_start_pre: got %0d expected 45", pre_rd_addr); end
      end
    end
    checks++;
    if (dcnt != 1 || dcyc != 122) begin
      failures++;
      $display("FAIL busy_start_done: got count=%0d cycle=%0d expected 1 122", dcnt, dcyc);
    end
    $display("test_start_busy done");
  endtask

  task automatic test_back_to_back();
    int dcnt = 0, dcyc2 = -1;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (c == 1 || c == 124) start = 1'b0;
      if (c == 122) begin
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1: got %b expected 1", done); end
      end
      if (c == 123) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done); end
        go(100, 4, 200, 8);
      end
      if (c == 124) begin
        checks++;
        if (busy !== 1'b1 || crt_rd_en !== 1'b1 || crt_rd_addr !== 10'd103) begin
          failures++;
          $display("FAIL b2b_restart: got busy=%b en=%b addr=%0d expected 1 1 103", busy, crt_rd_en, crt_rd_addr);
        end
      end
      if (c > 123 && done === 1'b1) begin
        dcnt++;
        dcyc2 = c;
        checks++;
        if (pre_pixel !== 8'd245) begin failures++; $display("FAIL b2b_last_pix: got %0d expected 245", pre_pixel); end
      end
    end
    checks++;
    if (dcnt != 1 || dcyc2 != 245) begin
      failures++;
      $display("FAIL b2b_done2: got count=%0d cycle=%0d expected 1 245", dcnt, dcyc2);
    end
    $display("test_back_to_back done");
  endtask

`ifdef ME_FEEDER_ABORT_EN
  task automatic test_abort();
    int dcnt = 0, acnt = 0, pvcnt = 0;
    do_reset();
    go(0, 4, 0, 8);
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (aborted === 1'b1) acnt++;
      if (done === 1'b1) dcnt++;
      if (c >= 41 && pre_valid === 1'b1) pvcnt++;
      if (c == 40) begin
        abort = 1'b1;
        #1;
        checks++;
        if ({crt_rd_en, pre_rd_en} !== 2'b00) begin failures++; $display("FAIL abort_strobes: got %b expected 00", {crt_rd_en, pre_rd_en}); end
      end
      if (c == 41) begin
        abort = 1'b0;
        checks++;
        if ({busy, aborted, pre_valid, crt_keep, done} !== 5'b01010) begin
          failures++;
          $display("FAIL abort_next: got busy/aborted/pv/keep/done=%b expected 01010", {busy, aborted, pre_valid, crt_keep, done});
        end
      end
      if (c == 42) begin
        checks++;
        if (aborted !== 1'b0) begin failures++; $display("FAIL abort_pulse: got %b expected 0", aborted); end
      end
      if (c == 100) abort = 1'b1;
      if (c == 101) abort = 1'b0;
    end
    checks++;
    if (dcnt != 0 || acnt != 1 || pvcnt != 0) begin
      failures++;
      $display("FAIL abort_summary: got done=%0d aborted=%0d pv=%0d expected 0 1 0", dcnt, acnt, pvcnt);
    end
    $display("test_abort done");
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_data();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
`ifdef ME_FEEDER_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
